// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Counts rising edges of the neuron axon signal over fixed-length,
//   back-to-back measurement windows. It also tracks the shortest
//   inter-spike interval inside each window. Each finished window is
//   offered to the consumer through a valid/ready handshake. If a finished
//   window arrives while the previous result is still held and not being
//   taken, the new result is dropped and the sticky overrun flag is set.
//
// Ports
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous active-high reset
//   axon        in   1  spike level; a spike is a 0->1 transition
//   enable      in   1  run windows back to back while high
//   window      in   8  window length in cycles (0 = do not measure)
//   rate        out  8  spike count of the last delivered window
//   min_isi     out  8  smallest spike interval in that window (255 if < 2 spikes)
//   rate_valid  out  1  rate/min_isi hold an untaken result
//   rate_ready  in   1  consumer takes the result at an edge with rate_valid
//   overrun     out  1  sticky; a finished result was dropped
//
// state | meaning
// IDLE  | not measuring; waiting for enable with a non-zero window
// COUNT | inside a window, cyc runs 0..win_len-1

module spike_rate_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       axon,
  input  logic       enable,
  input  logic [7:0] window,
  output logic [7:0] rate,
  output logic [7:0] min_isi,
  output logic       rate_valid,
  input  logic       rate_ready,
  output logic       overrun
);

  localparam logic [7:0] SAT = 8'hFF;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic       axon_q;
  logic [7:0] win_len;
  logic [7:0] cyc;
  logic [7:0] spk_cnt;
  logic [7:0] min_acc;
  logic [7:0] gap;
  logic       gap_vld;

  logic       spike;
  logic       win_ok;
  logic       last_cyc;
  logic       start_win;
  logic       count_en;
  logic       win_end;
  logic       load_res;
  logic       take;

  logic [7:0] spk_cnt_nxt;
  logic [7:0] isi;
  logic [7:0] min_nxt;

  assign spike    = axon & ~axon_q;
  assign win_ok   = enable && (window != 8'd0);
  assign last_cyc = (cyc == (win_len - 8'd1));

  // Window-end values include a spike landing on the final cycle, so the
  // delivered result is taken from these next-values rather than the regs.
  assign spk_cnt_nxt = (spike && (spk_cnt != SAT)) ? spk_cnt + 8'd1 : spk_cnt;
  assign isi         = (gap == SAT) ? SAT : gap + 8'd1;
  assign min_nxt     = (spike && gap_vld && (isi < min_acc)) ? isi : min_acc;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (win_ok) begin
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        // A completed window is delivered even if enable dropped on its
        // last cycle; only then is the follow-on window decided.
        if (last_cyc) begin
          state_nxt = win_ok ? COUNT : IDLE;
        end else if (!enable) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    start_win = 1'b0;
    count_en  = 1'b0;
    win_end   = 1'b0;
    unique case (state)
      IDLE: begin
        start_win = win_ok;
      end
      COUNT: begin
        if (last_cyc) begin
          win_end   = 1'b1;
          start_win = win_ok;
        end else begin
          count_en  = enable;
        end
      end
      default: begin
        start_win = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Spike edge detector; runs in every state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axon_q <= 1'b0;
    end else begin
      axon_q <= axon;
    end
  end

  // ---------------------------------------------------------------------
  // Window datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_len <= 8'd0;
      cyc     <= 8'd0;
      spk_cnt <= 8'd0;
      min_acc <= SAT;
      gap     <= 8'd0;
      gap_vld <= 1'b0;
    end else if (start_win) begin
      // Window length is only sampled here, so mid-window changes wait.
      win_len <= window;
      cyc     <= 8'd0;
      spk_cnt <= 8'd0;
      min_acc <= SAT;
      gap     <= 8'd0;
      gap_vld <= 1'b0;
    end else if (count_en) begin
      cyc     <= cyc + 8'd1;
      spk_cnt <= spk_cnt_nxt;
      min_acc <= min_nxt;
      if (spike) begin
        gap     <= 8'd0;
        gap_vld <= 1'b1;
      end else if (gap_vld && (gap != SAT)) begin
        gap <= gap + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Result handshake and overrun
  // ---------------------------------------------------------------------
  assign take     = rate_valid && rate_ready;
  assign load_res = win_end && (!rate_valid || rate_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate       <= 8'd0;
      min_isi    <= SAT;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load_res) begin
        rate       <= spk_cnt_nxt;
        min_isi    <= min_nxt;
        rate_valid <= 1'b1;
      end else if (take) begin
        rate_valid <= 1'b0;
      end
      if (win_end && !load_res) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       axon;
  logic       enable;
  logic [7:0] window;
  logic [7:0] rate;
  logic [7:0] min_isi;
  logic       rate_valid;
  logic       rate_ready;
  logic       overrun;

  int tests_run    = 0;
  int tests_failed = 0;

  spike_rate_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .axon       (axon),
    .enable     (enable),
    .window     (window),
    .rate       (rate),
    .min_isi    (min_isi),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    enable     = 1'b0;
    axon       = 1'b0;
    window     = 8'd0;
    rate_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Reset values, then a level already high after reset must not count.
  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; axon = 1'b0; window = 8'd0; rate_ready = 1'b0;
    #2;
    tests_run++;
    if (rate !== 8'd0) begin tests_failed++; $display("FAIL reset_rate: got %0d expected 0", rate); end
    tests_run++;
    if (min_isi !== 8'd255) begin tests_failed++; $display("FAIL reset_min_isi: got %0d expected 255", min_isi); end
    tests_run++;
    if (rate_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b expected 0", rate_valid); end
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    do_reset;
    axon = 1'b1; enable = 1'b1; window = 8'd3; rate_ready = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) tick;
    tests_run++;
    if (rate_valid !== 1'b1) begin tests_failed++; $display("FAIL held_high_valid: got %0b expected 1", rate_valid); end
    tests_run++;
    if (rate !== 8'd0) begin tests_failed++; $display("FAIL held_high_rate: got %0d expected 0", rate); end
    tests_run++;
    if (min_isi !== 8'd255) begin tests_failed++; $display("FAIL held_high_min: got %0d expected 255", min_isi); end
  endtask

  task automatic test_basic;
    do_reset;
    window = 8'd10; enable = 1'b1; rate_ready = 1'b1;
    tick;
    for (int k = 0; k < 10; k++) begin
      axon = (k % 3 == 0);
      tick;
    end
    tests_run++;
    if (rate_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %0b expected 1", rate_valid); end
    tests_run++;
    if (rate !== 8'd4) begin tests_failed++; $display("FAIL basic_rate: got %0d expected 4", rate); end
    tests_run++;
    if (min_isi !== 8'd3) begin tests_failed++; $display("FAIL basic_min: got %0d expected 3", min_isi); end
    enable = 1'b0; axon = 1'b0;
    tick;
    tests_run++;
    if (rate_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_taken: got %0b expected 0", rate_valid); end
  endtask

  // Window 9 with period-3 pulses: every window identical; a transient
  // change on window inside the first window must not shorten it.
  task automatic test_back_to_back;
    do_reset;
    window = 8'd9; enable = 1'b1; rate_ready = 1'b1;
    tick;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 9; k++) begin
        axon = (k % 3 == 0);
        if (w == 0 && k == 3) window = 8'd5;
        if (w == 0 && k == 7) window = 8'd9;
        tick;
        if (k == 8) begin
          tests_run++;
          if (rate_valid !== 1'b1 || rate !== 8'd3 || min_isi !== 8'd3) begin
            tests_failed++;
            $display("FAIL b2b_result w%0d: got valid=%0b rate=%0d min=%0d expected 1/3/3", w, rate_valid, rate, min_isi);
          end
        end else begin
          tests_run++;
          if (rate_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_one_cycle w%0d k%0d: got valid=%0b expected 0", w, k, rate_valid);
          end
        end
      end
    end
  endtask

  task automatic test_long_pulse;
    do_reset;
    window = 8'd20; enable = 1'b1; rate_ready = 1'b1;
    tick;
    for (int k = 0; k < 20; k++) begin
      axon = (k < 15);
      tick;
    end
    tests_run++;
    if (rate_valid !== 1'b1 || rate !== 8'd1 || min_isi !== 8'd255) begin
      tests_failed++;
      $display("FAIL long_pulse: got valid=%0b rate=%0d min=%0d expected 1/1/255", rate_valid, rate, min_isi);
    end
  endtask

  // Windows of 5: w1 one spike, w2 two spikes 2 apart (dropped),
  // w3 spikes at local 0,2,4 including the final cycle.
  task automatic test_overrun;
    do_reset;
    window = 8'd5; enable = 1'b1; rate_ready = 1'b0;
    tick;
    for (int k = 0; k < 15; k++) begin
      axon = (k == 1 || k == 5 || k == 7 || k == 10 || k == 12 || k == 14);
      if (k == 10) rate_ready = 1'b1;
      tick;
      if (k == 4) begin
        tests_run++;
        if (rate_valid !== 1'b1 || rate !== 8'd1 || min_isi !== 8'd255 || overrun !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovr_first: got v=%0b r=%0d m=%0d o=%0b expected 1/1/255/0", rate_valid, rate, min_isi, overrun);
        end
      end
      if (k == 9) begin
        tests_run++;
        if (rate_valid !== 1'b1 || rate !== 8'd1 || min_isi !== 8'd255 || overrun !== 1'b1) begin
          tests_failed++;
          $display("FAIL ovr_drop: got v=%0b r=%0d m=%0d o=%0b expected 1/1/255/1", rate_valid, rate, min_isi, overrun);
        end
      end
      if (k == 10) begin
        tests_run++;
        if (rate_valid !== 1'b0 || overrun !== 1'b1) begin
          tests_failed++;
          $display("FAIL ovr_take: got v=%0b o=%0b expected 0/1", rate_valid, overrun);
        end
      end
      if (k == 14) begin
        tests_run++;
        if (rate_valid !== 1'b1 || rate !== 8'd3 || min_isi !== 8'd2) begin
          tests_failed++;
          $display("FAIL ovr_third: got v=%0b r=%0d m=%0d expected 1/3/2", rate_valid, rate, min_isi);
        end
      end
    end
  endtask

  // Follows test_overrun with a result held and overrun set.
  task automatic test_reset_mid;
    axon = 1'b0; rate_ready = 1'b0;
    tick;
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if (rate !== 8'd0 || min_isi !== 8'd255 || rate_valid !== 1'b0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got r=%0d m=%0d v=%0b o=%0b expected 0/255/0/0", rate, min_isi, rate_valid, overrun);
    end
    do_reset;
  endtask

  task automatic test_simultaneous;
    do_reset;
    window = 8'd4; enable = 1'b1; rate_ready = 1'b0;
    tick;
    for (int k = 0; k < 8; k++) begin
      axon = (k == 0 || k == 4 || k == 6);
      rate_ready = (k == 7);
      tick;
      if (k == 6) begin
        tests_run++;
        if (rate_valid !== 1'b1 || rate !== 8'd1 || min_isi !== 8'd255) begin
          tests_failed++;
          $display("FAIL simul_held: got v=%0b r=%0d m=%0d expected 1/1/255", rate_valid, rate, min_isi);
        end
      end
      if (k == 7) begin
        tests_run++;
        if (rate_valid !== 1'b1 || rate !== 8'd2 || min_isi !== 8'd2 || overrun !== 1'b0) begin
          tests_failed++;
          $display("FAIL simul_load: got v=%0b r=%0d m=%0d o=%0b expected 1/2/2/0", rate_valid, rate, min_isi, overrun);
        end
      end
    end
    rate_ready = 1'b0;
  endtask

  task automatic test_window_one;
    logic [5:0] pat;
    logic [5:0] exp_r;
    pat   = 6'b101101;   // bit k = axon level before edge k
    exp_r = 6'b100101;   // spike only where previous level was low
    do_reset;
    window = 8'd1; enable = 1'b1; rate_ready = 1'b1;
    tick;
    for (int k = 0; k < 6; k++) begin
      axon = pat[k];
      tick;
      tests_run++;
      if (rate_valid !== 1'b1 || rate !== {7'd0, exp_r[k]} || min_isi !== 8'd255) begin
        tests_failed++;
        $display("FAIL win1 k%0d: got v=%0b r=%0d m=%0d expected 1/%0d/255", k, rate_valid, rate, min_isi, exp_r[k]);
      end
    end
  endtask

  task automatic test_saturation;
    do_reset;
    window = 8'd255; enable = 1'b1; rate_ready = 1'b1;
    tick;
    for (int k = 0; k < 255; k++) begin
      axon = (k % 2 == 0);
      tick;
    end
    tests_run++;
    if (rate_valid !== 1'b1 || rate !== 8'd128 || min_isi !== 8'd2 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL win255: got v=%0b r=%0d m=%0d o=%0b expected 1/128/2/0", rate_valid, rate, min_isi, overrun);
    end
  endtask

  task automatic test_abort;
    int bad;
    do_reset;
    window = 8'd10; enable = 1'b1; rate_ready = 1'b1;
    tick;
    axon = 1'b1; tick;
    axon = 1'b0; tick;
    axon = 1'b1; tick;
    axon = 1'b0; enable = 1'b0;
    tick;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      tick;
      if (rate_valid !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL abort_no_result: got %0d cycles with valid, expected 0", bad);
    end
    window = 8'd3; enable = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      axon = (k == 1);
      tick;
    end
    tests_run++;
    if (rate_valid !== 1'b1 || rate !== 8'd1 || min_isi !== 8'd255) begin
      tests_failed++;
      $display("FAIL abort_restart: got v=%0b r=%0d m=%0d expected 1/1/255", rate_valid, rate, min_isi);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_long_pulse;
    test_overrun;
    test_reset_mid;
    test_simultaneous;
    test_window_one;
    test_saturation;
    test_abort;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
